// File: rtl/uart_pkg.sv
// uart_pkg: constants, types and baud divisor helpers shared by the UART
// receive datapath and its bit-time counter.
//   FRAME_W     width of the receive shift register (start bit not stored)
//   CNT_W       width of the bit-time counter
//   baud_div()  round(clk_hz / baud) for a 4-bit baud index
//   div_table() all sixteen divisors, folded to constants at elaboration
package uart_pkg;

  localparam int FRAME_W    = 10;
  localparam int CNT_W      = 19;
  localparam int BAUD_SEL_W = 4;
  localparam int NUM_BAUD   = 16;
  localparam int BIT_CNT_W  = 4;

  typedef enum logic [BAUD_SEL_W-1:0] {
    BAUD_300    = 4'd0,
    BAUD_1200   = 4'd1,
    BAUD_2400   = 4'd2,
    BAUD_4800   = 4'd3,
    BAUD_9600   = 4'd4,
    BAUD_19200  = 4'd5,
    BAUD_38400  = 4'd6,
    BAUD_57600  = 4'd7,
    BAUD_115200 = 4'd8,
    BAUD_230400 = 4'd9,
    BAUD_460800 = 4'd10,
    BAUD_921600 = 4'd11
  } baud_idx_e;

  // Frame format as {eight, pen}.
  typedef enum logic [1:0] {
    FMT_7N = 2'b00,
    FMT_7P = 2'b01,
    FMT_8N = 2'b10,
    FMT_8P = 2'b11
  } frame_fmt_e;

  typedef logic [NUM_BAUD-1:0][CNT_W-1:0] div_tab_t;

  function automatic int unsigned baud_rate(input logic [BAUD_SEL_W-1:0] idx);
    int unsigned rate;
    case (idx)
      BAUD_300:    rate = 300;
      BAUD_1200:   rate = 1_200;
      BAUD_2400:   rate = 2_400;
      BAUD_4800:   rate = 4_800;
      BAUD_9600:   rate = 9_600;
      BAUD_19200:  rate = 19_200;
      BAUD_38400:  rate = 38_400;
      BAUD_57600:  rate = 57_600;
      BAUD_115200: rate = 115_200;
      BAUD_230400: rate = 230_400;
      BAUD_460800: rate = 460_800;
      default:     rate = 921_600;  // indices 11..15
    endcase
    return rate;
  endfunction

  // Rounded divide: (clk + baud/2) / baud.
  function automatic logic [CNT_W-1:0] baud_div(input int unsigned clk_hz,
                                                input logic [BAUD_SEL_W-1:0] idx);
    int unsigned rate;
    int unsigned div;
    rate = baud_rate(idx);
    div  = (clk_hz + rate / 2) / rate;
    return CNT_W'(div);
  endfunction

  function automatic div_tab_t div_table(input int unsigned clk_hz);
    div_tab_t tab;
    for (int i = 0; i < NUM_BAUD; i++) begin
      tab[i] = baud_div(clk_hz, BAUD_SEL_W'(i));
    end
    return tab;
  endfunction

  // Samples per frame after the start bit: data + optional parity + stop.
  function automatic logic [BIT_CNT_W-1:0] sample_count(input logic eight, input logic pen);
    return BIT_CNT_W'(8) + BIT_CNT_W'(eight) + BIT_CNT_W'(pen);
  endfunction

endpackage

// File: rtl/uart_rx_datapath_bit_time_counter.sv
// bit_time_counter: divisor latch and bit-time counter for the UART receiver.
// Ports:
//   clk, rst      system clock, asynchronous active-low reset
//   start         half-bit timing while the FSM qualifies the start bit
//   do_it         frame in progress; counter held at 0 while low
//   baud_sel      baud index, captured on the do_it rising edge
//   btu           single-cycle bit-time-up strobe
//   frame_start   one-cycle pulse on the do_it rising edge
module bit_time_counter
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  do_it,
  input  logic [BAUD_SEL_W-1:0] baud_sel,
  output logic                  btu,
  output logic                  frame_start
);

  localparam div_tab_t DIV_TAB = div_table(CLK_HZ);

  logic             do_it_q;
  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] div_eff;
  logic [CNT_W-1:0] limit;
  logic [CNT_W-1:0] count;

  assign frame_start = do_it & ~do_it_q;

  // In the rising-edge cycle the latch has not loaded yet, so use the
  // table value directly; afterwards baud_sel changes are ignored.
  assign div_eff = frame_start ? DIV_TAB[baud_sel] : div_q;
  assign limit   = start ? (div_eff >> 1) : div_eff;
  assign btu     = do_it & (count == (limit - CNT_W'(1)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      do_it_q <= 1'b0;
      div_q   <= '0;
    end else begin
      do_it_q <= do_it;
      if (frame_start) begin
        div_q <= DIV_TAB[baud_sel];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (!do_it || btu) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_datapath.sv
// uart_rx_datapath: receive datapath of the UART, sitting under the receive
// control FSM. Times bits, samples rx mid-bit, deserialises 7/8-bit frames
// with optional parity and holds the byte plus status for the host.
// Optional feature macro: UART_RX_SYNC_EN (2-flop rx synchroniser, reset to 1).
// Ports:
//   clk, rst      system clock, asynchronous active-low reset
//   rx            serial line, idle high
//   start, do_it  FSM phase inputs (start-bit qualify, frame in progress)
//   baud_sel      baud index, latched per frame
//   eight, pen    8 data bits / parity enable
//   ohel          parity sense, 1 = odd
//   clr_rdy       host read acknowledge, clears rx_rdy and ovf
//   rx_s          conditioned rx, also feeds the FSM
//   btu, done     strobes back to the FSM
//   rx_data       received byte (bit 7 = 0 in 7-bit mode)
//   rx_rdy        byte available
//   perr, ferr    parity / framing error for the held byte
//   ovf           a frame completed while rx_rdy was still set
module uart_rx_datapath
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic                  start,
  input  logic                  do_it,
  input  logic [BAUD_SEL_W-1:0] baud_sel,
  input  logic                  eight,
  input  logic                  pen,
  input  logic                  ohel,
  input  logic                  clr_rdy,
  output logic                  rx_s,
  output logic                  btu,
  output logic                  done,
  output logic [7:0]            rx_data,
  output logic                  rx_rdy,
  output logic                  perr,
  output logic                  ferr,
  output logic                  ovf
);

  logic                 frame_start;
  logic                 sample;
  logic                 last_sample;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [BIT_CNT_W-1:0] k_len;
  logic [FRAME_W-1:0]   sr;
  frame_fmt_e           fmt;
  logic [7:0]           data_ext;
  logic                 par_ext;
  logic                 stop_ext;
  logic                 perr_next;

`ifdef UART_RX_SYNC_EN
  logic [1:0] rx_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sync <= 2'b11;
    end else begin
      rx_sync <= {rx_sync[0], rx};
    end
  end

  assign rx_s = rx_sync[1];
`else
  assign rx_s = rx;
`endif

  bit_time_counter #(
    .CLK_HZ (CLK_HZ)
  ) u_btc (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .do_it       (do_it),
    .baud_sel    (baud_sel),
    .btu         (btu),
    .frame_start (frame_start)
  );

  // The btu seen while start is high is the mid-start-bit check, not data.
  assign sample      = btu & ~start & do_it;
  assign k_len       = sample_count(eight, pen);
  assign last_sample = sample & ((bit_cnt + BIT_CNT_W'(1)) == k_len);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
    end else if (!do_it) begin
      bit_cnt <= '0;
    end else if (sample) begin
      bit_cnt <= bit_cnt + BIT_CNT_W'(1);
    end
  end

  // Shifts right so the stop bit always lands in sr[9] and the field
  // positions depend only on the frame format.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr <= '0;
    end else if (frame_start) begin
      sr <= '0;
    end else if (sample) begin
      sr <= {rx_s, sr[FRAME_W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done <= 1'b0;
    end else begin
      done <= last_sample;
    end
  end

  assign fmt = frame_fmt_e'({eight, pen});

  always_comb begin
    data_ext = '0;
    par_ext  = 1'b0;
    case (fmt)
      FMT_7N: data_ext = {1'b0, sr[8:2]};
      FMT_7P: begin
        data_ext = {1'b0, sr[7:1]};
        par_ext  = sr[8];
      end
      FMT_8N: data_ext = sr[8:1];
      FMT_8P: begin
        data_ext = sr[7:0];
        par_ext  = sr[8];
      end
      default: begin
        data_ext = '0;
        par_ext  = 1'b0;
      end
    endcase
  end

  assign stop_ext  = sr[FRAME_W-1];
  assign perr_next = pen & (^data_ext ^ par_ext ^ ohel);

  // done takes priority over clr_rdy; a coincident acknowledge still
  // suppresses the overrun for this byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data <= '0;
      rx_rdy  <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      ovf     <= 1'b0;
    end else if (done) begin
      rx_data <= data_ext;
      perr    <= perr_next;
      ferr    <= ~stop_ext;
      rx_rdy  <= 1'b1;
      ovf     <= clr_rdy ? 1'b0 : (ovf | rx_rdy);
    end else if (clr_rdy) begin
      rx_rdy  <= 1'b0;
      ovf     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_datapath.sv
`timescale 1ns/1ps
module tb_uart_rx_datapath;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       start = 1'b0;
  logic       do_it = 1'b0;
  logic [3:0] baud_sel = 4'd8;
  logic       eight = 1'b1;
  logic       pen = 1'b0;
  logic       ohel = 1'b0;
  logic       clr_rdy = 1'b0;
  logic       rx_s;
  logic       btu;
  logic       done;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       perr;
  logic       ferr;
  logic       ovf;

  int errors = 0;
  int checks = 0;
  int div_clk = 868;

  always #5 clk = ~clk;

  uart_rx_datapath #(.CLK_HZ(100_000_000)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .start    (start),
    .do_it    (do_it),
    .baud_sel (baud_sel),
    .eight    (eight),
    .pen      (pen),
    .ohel     (ohel),
    .clr_rdy  (clr_rdy),
    .rx_s     (rx_s),
    .btu      (btu),
    .done     (done),
    .rx_data  (rx_data),
    .rx_rdy   (rx_rdy),
    .perr     (perr),
    .ferr     (ferr),
    .ovf      (ovf)
  );

  // Behavioural receive-control FSM with registered start/do_it.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      start <= 1'b0;
      do_it <= 1'b0;
    end else if (!do_it) begin
      if (!rx_s) begin
        start <= 1'b1;
        do_it <= 1'b1;
      end
    end else if (start) begin
      if (btu) begin
        start <= 1'b0;
        if (rx_s) do_it <= 1'b0;
      end
    end else if (done) begin
      do_it <= 1'b0;
    end
  end

  // Event monitor, sampled on the falling edge.
  int cyc = 0;
  int rise_cyc = 0;
  int samp_n = 0;
  int done_n = 0;
  int btu_cyc[$];
  logic do_it_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (btu) begin
      btu_cyc.push_back(cyc);
      if (!start) samp_n++;
    end
    if (done) done_n++;
    if (do_it && !do_it_prev) rise_cyc = cyc;
    do_it_prev = do_it;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr_pulse();
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
    @(negedge clk);
  endtask

  // Drives start, data LSB first, optional parity, then holds the stop bit
  // until done is seen; the line returns high in the done cycle.
  task automatic send_frame(input logic [7:0] data, input logic par,
                            input logic stop_bit, input bit clr_at_done);
    int nb;
    int t;
    nb = eight ? 8 : 7;
    rx = 1'b0;
    repeat (div_clk) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      rx = data[i];
      repeat (div_clk) @(negedge clk);
    end
    if (pen) begin
      rx = par;
      repeat (div_clk) @(negedge clk);
    end
    rx = stop_bit;
    t = 0;
    while (!done && t < 2 * div_clk) begin
      @(negedge clk);
      t++;
    end
    check_val("done_seen", 32'(done), 32'd1);
    rx = 1'b1;
    if (clr_at_done) clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
  endtask

  initial begin
    int b0;
    int d0;
    int s0;

    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_rx_data", 32'(rx_data), 32'h0);
    check_val("rst_rx_rdy",  32'(rx_rdy),  32'd0);
    check_val("rst_perr",    32'(perr),    32'd0);
    check_val("rst_ferr",    32'(ferr),    32'd0);
    check_val("rst_ovf",     32'(ovf),     32'd0);
    check_val("rst_done",    32'(done),    32'd0);
    check_val("rst_btu",     32'(btu),     32'd0);
    check_val("rst_rx_s",    32'(rx_s),    32'd1);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // 115200 8N1, 0xA5
    baud_sel = 4'd8; div_clk = 868; eight = 1'b1; pen = 1'b0;
    b0 = btu_cyc.size(); d0 = done_n; s0 = samp_n;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check_val("t1_btu_count", 32'(btu_cyc.size() - b0), 32'd10);
    if (btu_cyc.size() >= b0 + 10) begin
      check_val("t1_first_btu", 32'(btu_cyc[b0] - rise_cyc + 1), 32'd434);
      check_val("t1_btu_period_a", 32'(btu_cyc[b0+1] - btu_cyc[b0]), 32'd868);
      check_val("t1_btu_period_b", 32'(btu_cyc[b0+9] - btu_cyc[b0+8]), 32'd868);
    end
    check_val("t1_samples", 32'(samp_n - s0), 32'd9);
    check_val("t1_done_cnt", 32'(done_n - d0), 32'd1);
    check_val("t1_rx_data", 32'(rx_data), 32'hA5);
    check_val("t1_rx_rdy",  32'(rx_rdy),  32'd1);
    check_val("t1_perr",    32'(perr),    32'd0);
    check_val("t1_ferr",    32'(ferr),    32'd0);
    check_val("t1_ovf",     32'(ovf),     32'd0);
    clr_pulse();
    check_val("t1_clr_rx_rdy", 32'(rx_rdy), 32'd0);
    check_val("t1_clr_data_hold", 32'(rx_data), 32'hA5);

    // 460800 (DIV 217) 7-bit odd parity
    baud_sel = 4'd10; div_clk = 217; eight = 1'b0; pen = 1'b1; ohel = 1'b1;
    send_frame(8'h41, 1'b1, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check_val("t2_7o_data", 32'(rx_data), 32'h41);
    check_val("t2_7o_perr_ok", 32'(perr), 32'd0);
    check_val("t2_7o_rx_rdy", 32'(rx_rdy), 32'd1);
    clr_pulse();
    send_frame(8'h41, 1'b0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check_val("t2_7o_data_b", 32'(rx_data), 32'h41);
    check_val("t2_7o_perr_bad", 32'(perr), 32'd1);
    clr_pulse();
    check_val("t2_perr_hold", 32'(perr), 32'd1);

    // 8-bit even parity, 0xD3 has five ones so parity bit 1 is correct
    eight = 1'b1; pen = 1'b1; ohel = 1'b0;
    send_frame(8'hD3, 1'b1, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check_val("t2_8e_data", 32'(rx_data), 32'hD3);
    check_val("t2_8e_perr", 32'(perr), 32'd0);
    clr_pulse();

    // 8N1 framing error
    pen = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check_val("t3_ferr", 32'(ferr), 32'd1);
    check_val("t3_rx_rdy", 32'(rx_rdy), 32'd1);
    check_val("t3_data", 32'(rx_data), 32'h5A);
    clr_pulse();

    // Overrun: two frames with no acknowledge
    send_frame(8'h12, 1'b0, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    send_frame(8'h34, 1'b0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check_val("t4_data", 32'(rx_data), 32'h34);
    check_val("t4_ovf", 32'(ovf), 32'd1);
    check_val("t4_rx_rdy", 32'(rx_rdy), 32'd1);
    check_val("t4_ferr", 32'(ferr), 32'd0);
    clr_pulse();
    check_val("t4_clr_rx_rdy", 32'(rx_rdy), 32'd0);
    check_val("t4_clr_ovf", 32'(ovf), 32'd0);

    // False start at 115200: 200 clk low, FSM aborts at the half-bit check
    baud_sel = 4'd8; div_clk = 868;
    b0 = btu_cyc.size(); d0 = done_n;
    rx = 1'b0;
    repeat (200) @(negedge clk);
    rx = 1'b1;
    repeat (1500) @(negedge clk);
    check_val("t5_btu_once", 32'(btu_cyc.size() - b0), 32'd1);
    check_val("t5_no_done", 32'(done_n - d0), 32'd0);
    check_val("t5_data_hold", 32'(rx_data), 32'h34);
    check_val("t5_rx_rdy", 32'(rx_rdy), 32'd0);
    check_val("t5_ovf", 32'(ovf), 32'd0);

    // clr_rdy coincident with done while a byte is already waiting
    baud_sel = 4'd10; div_clk = 217;
    send_frame(8'h55, 1'b0, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    send_frame(8'h66, 1'b0, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    check_val("t6_rx_rdy", 32'(rx_rdy), 32'd1);
    check_val("t6_ovf", 32'(ovf), 32'd0);
    check_val("t6_data", 32'(rx_data), 32'h66);

    // Reset mid-frame
    d0 = done_n;
    rx = 1'b0;
    repeat (600) @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("t7_rx_data", 32'(rx_data), 32'h0);
    check_val("t7_rx_rdy", 32'(rx_rdy), 32'd0);
    check_val("t7_ovf", 32'(ovf), 32'd0);
    check_val("t7_perr", 32'(perr), 32'd0);
    check_val("t7_ferr", 32'(ferr), 32'd0);
    check_val("t7_done", 32'(done), 32'd0);
    check_val("t7_btu", 32'(btu), 32'd0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3000) @(negedge clk);
    check_val("t7_no_done_after", 32'(done_n - d0), 32'd0);
    check_val("t7_rx_rdy_after", 32'(rx_rdy), 32'd0);

`ifdef UART_RX_SYNC_EN
    rst = 1'b0;
    rx = 1'b0;
    #1;
    check_val("sync_rst_rx_s", 32'(rx_s), 32'd1);
    repeat (2) @(negedge clk);
    check_val("sync_rst_hold", 32'(rx_s), 32'd1);
    rx = 1'b1;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    check_val("sync_lag1", 32'(rx_s), 32'd1);
    @(negedge clk);
    check_val("sync_lag2", 32'(rx_s), 32'd0);
    rx = 1'b1;
    repeat (1000) @(negedge clk);
`else
    rx = 1'b0;
    #1;
    check_val("pass_rx_s_low", 32'(rx_s), 32'd0);
    rx = 1'b1;
    #1;
    check_val("pass_rx_s_high", 32'(rx_s), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
